pb_conditioner: RTL

Two-channel pushbutton conditioner placed directly upstream of the PWM duty-cycle stage. It converts raw, bouncing, asynchronous increment and decrement buttons into clean single-cycle pulses on `inc_pulse` and `dec_pulse`. These outputs drive the PWM block's `pb_inc` and `pb_dec` inputs, so each physical press changes the duty cycle exactly once.

---
 rtl/pb_pkg.sv | 27 ++
 rtl/pb_channel.sv | 117 +++++++++++
 rtl/pb_conditioner.sv | 58 +++++
 3 files changed

// File: rtl/pb_pkg.sv
// Shared types and constants for the pushbutton conditioner.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } pb_state_t;

    // 20 ms debounce, 500 ms repeat delay, 100 ms repeat rate at 50 MHz
    localparam int unsigned PB_DEBOUNCE_CYCLES_DEF     = 1_000_000;
    localparam int unsigned PB_REPEAT_DELAY_CYCLES_DEF = 25_000_000;
    localparam int unsigned PB_REPEAT_RATE_CYCLES_DEF  = 5_000_000;

    // Counter width wide enough to hold (largest cycle parameter - 1)
    function automatic int unsigned pb_cnt_width(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pb_channel.sv
// One pushbutton channel: 2-FF synchronizer, debounce FSM, optional auto-repeat.
// Auto-repeat is built only when PB_CONDITIONER_AUTO_REPEAT_EN is defined.
module pb_channel
    import pb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = PB_DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY_CYCLES = PB_REPEAT_DELAY_CYCLES_DEF,
    parameter int unsigned REPEAT_RATE_CYCLES  = PB_REPEAT_RATE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic raw_pulse_c,
    output logic held
);

    localparam int unsigned CNT_W =
        pb_cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
    localparam logic [CNT_W-1:0] DB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    pb_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef PB_CONDITIONER_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LOAD = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_RATE_LOAD  = CNT_W'(REPEAT_RATE_CYCLES - 1);
    logic [CNT_W-1:0] rpt_q, rpt_d;

    // Repeat timer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rpt_q <= '0;
        else      rpt_q <= rpt_d;
    end
`endif

    assign s = sync_q[1];

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[0], btn_raw};
    end

    // State, debounce counter and held level (held follows the next state)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held    <= (state_d == HELD) || (state_d == REL_WAIT);
        end
    end

    // Next-state, counter loads/decrements and raw pulse generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        raw_pulse_c = 1'b0;
`ifdef PB_CONDITIONER_AUTO_REPEAT_EN
        rpt_d       = rpt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = DB_LOAD;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d     = HELD;
                    raw_pulse_c = 1'b1;
`ifdef PB_CONDITIONER_AUTO_REPEAT_EN
                    rpt_d       = RPT_DELAY_LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = REL_WAIT;
                    cnt_d   = DB_LOAD;
                end
`ifdef PB_CONDITIONER_AUTO_REPEAT_EN
                else if (rpt_q == '0) begin
                    raw_pulse_c = 1'b1;
                    rpt_d       = RPT_RATE_LOAD;
                end else begin
                    rpt_d = rpt_q - CNT_W'(1);
                end
`endif
            end
            REL_WAIT: begin
                if (s) begin
                    state_d = HELD;
`ifdef PB_CONDITIONER_AUTO_REPEAT_EN
                    rpt_d   = RPT_DELAY_LOAD;
`endif
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/pb_conditioner.sv
// Two-channel pushbutton conditioner feeding the PWM duty-cycle inc/dec inputs.
// Optional auto-repeat: define PB_CONDITIONER_AUTO_REPEAT_EN.
module pb_conditioner
    import pb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = PB_DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY_CYCLES = PB_REPEAT_DELAY_CYCLES_DEF,
    parameter int unsigned REPEAT_RATE_CYCLES  = PB_REPEAT_RATE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic inc_held,
    output logic dec_held
);

    logic inc_raw_c;
    logic dec_raw_c;

    pb_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
    ) u_inc (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_inc_raw),
        .raw_pulse_c (inc_raw_c),
        .held        (inc_held)
    );

    pb_channel #(
        .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
    ) u_dec (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_dec_raw),
        .raw_pulse_c (dec_raw_c),
        .held        (dec_held)
    );

    // Register pulses; coincident inc and dec cancel out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
        end else begin
            inc_pulse <= inc_raw_c & ~dec_raw_c;
            dec_pulse <= dec_raw_c & ~inc_raw_c;
        end
    end

endmodule
